mux_scan_seq: RTL and testbench

//  Upstream sequencer for the 10:1 16-bit word mux. On start it steps mux_sel
//  0..NUM_IN-1, registers the selected word each step and delivers it on a

---
 rtl/mux_scan_seq_pkg.sv | 23 ++
 rtl/mux_scan_seq_if.sv | 38 +++
 rtl/mux_scan_seq.sv | 98 +++++++++
 tb/tb_mux_scan_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the mux scan sequencer, the 10:1 word mux and the downstream stage.
// Holds the default geometry and the sequencer state encoding.
package mux_scan_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_IN = 10;
  localparam int unsigned SEL_W  = 4;
  // Wide enough for NUM_IN full-scale words, so the scan sum never wraps.
  localparam int unsigned SUM_W  = DATA_W + SEL_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCapt = 2'd1,
    StSend = 2'd2,
    StFin  = 2'd3
  } state_e;

  // Index of the final word in a scan.
  function automatic logic [SEL_W-1:0] last_idx();
    return SEL_W'(NUM_IN - 1);
  endfunction

endpackage

// File: rtl/mux_scan_seq_if.sv
// Mux select/data pair plus the captured-word valid/ready stream of the scan sequencer.
// The master side is the sequencer; the slave side is the mux together with the consumer.
interface mux_scan_seq_if
  import mux_scan_seq_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned SelW  = SEL_W
);

  logic [SelW-1:0]  mux_sel;
  logic [DataW-1:0] mux_data;
  logic [DataW-1:0] out_data;
  logic [SelW-1:0]  out_idx;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output mux_sel,
    input  mux_data,
    output out_data,
    output out_idx,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mux_sel,
    output mux_data,
    input  out_data,
    input  out_idx,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mux_scan_seq.sv
// Scan sequencer: steps the mux select over every input, registers each selected word
// and streams it out with its index, a last flag and a running sum of the scan.
module mux_scan_seq
  import mux_scan_seq_pkg::*;
#(
  parameter int unsigned DataW = DATA_W,
  parameter int unsigned NumIn = NUM_IN,
  parameter int unsigned SelW  = SEL_W,
  parameter int unsigned SumW  = SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  mux_scan_seq_if.master   bus,
  output logic             busy,
  output logic             done,
  output logic [SumW-1:0]  sum
);

  localparam logic [SelW-1:0] LastIdx = SelW'(NumIn - 1);

  state_e            state_q;
  // Doubles as the scan index: it equals idx in CAPT/SEND and is parked at 0 otherwise.
  logic [SelW-1:0]   sel_q;
  logic [DataW-1:0]  out_data_q;
  logic [SelW-1:0]   out_idx_q;
  logic              out_last_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [SumW-1:0]   sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StCapt;
            sel_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StCapt: begin
          out_data_q  <= bus.mux_data;
          out_idx_q   <= sel_q;
          out_last_q  <= (sel_q == LastIdx);
          sum_q       <= sum_q + SumW'(bus.mux_data);
          out_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          // Word and flags stay frozen until the consumer takes them.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= StFin;
              sel_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StCapt;
              sel_q   <= sel_q + SelW'(1);
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mux_sel   = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sum           = sum_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq with a behavioural 10:1 mux and an expected-word scoreboard.
module tb_mux_scan_seq;
  import mux_scan_seq_pkg::*;

  typedef struct packed {
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum;
  logic [DATA_W-1:0] in_words [NUM_IN];
  logic [DATA_W-1:0] mux_out;

  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int t0 = 0;
  int words;
  int done_cnt;
  int done_cyc;
  int first_valid;
  exp_t sb [$];

  always #5 clk = ~clk;

  mux_scan_seq_if #(.DataW(DATA_W), .SelW(SEL_W)) bus ();

  // Behavioural 10:1 word mux, combinational from mux_sel.
  always_comb begin
    mux_out = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.mux_sel == SEL_W'(k)) mux_out = in_words[k];
    end
  end
  assign bus.mux_data  = mux_out;
  assign bus.out_ready = out_ready;

  mux_scan_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_sb();
    sb.delete();
    for (int k = 0; k < NUM_IN; k++) begin
      sb.push_back('{idx: SEL_W'(k), data: in_words[k], last: (k == NUM_IN - 1)});
    end
  endtask

  function automatic logic [SUM_W-1:0] model_sum();
    logic [SUM_W-1:0] s = '0;
    for (int k = 0; k < NUM_IN; k++) s = s + SUM_W'(in_words[k]);
    return s;
  endfunction

  // Observe the cycle about to end (inputs already driven), then advance one clock.
  task automatic cyc();
    exp_t              e;
    logic              pv;
    logic              pr;
    logic              prst;
    logic [DATA_W-1:0] pd;
    logic [SEL_W-1:0]  pi;
    pv   = bus.out_valid;
    pr   = out_ready;
    prst = rst;
    pd   = bus.out_data;
    pi   = bus.out_idx;
    if (!rst && bus.out_valid === 1'b1 && out_ready) begin
      words++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow: observed=word idx %0h expected=no word", bus.out_idx);
      end else begin
        e = sb.pop_front();
        check("word_idx", 32'(bus.out_idx), 32'(e.idx));
        check("word_data", 32'(bus.out_data), 32'(e.data));
        check("word_last", 32'(bus.out_last), 32'(e.last));
        check("send_mux_sel", 32'(bus.mux_sel), 32'(e.idx));
      end
    end
    if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = cnt - t0;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cnt - t0;
    end
    @(posedge clk);
    #1;
    cnt++;
    if (pv === 1'b1 && !pr && !prst) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(pd));
      check("hold_idx", 32'(bus.out_idx), 32'(pi));
    end
  endtask

  // Full scan: optional stall on one index, optional extra start pulses mid-scan and in FIN.
  task automatic run_scan(input int stall_idx, input int stall_len, input int restart_at,
                          input bit fin_start, input int exp_done);
    logic [SUM_W-1:0] exp_sum;
    int stalled;
    int budget;
    int cyc_no;
    stalled = 0;
    budget = 200;
    exp_sum = model_sum();
    load_sb();
    words = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_valid = -1;
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cnt;
    cyc();
    start = 1'b0;
    while (done_cnt == 0 && budget > 0) begin
      cyc_no = cnt - t0;
      if (bus.out_valid === 1'b1 && int'(bus.out_idx) == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        check("stall_mux_sel", 32'(bus.mux_sel), 32'(stall_idx));
      end else begin
        out_ready = 1'b1;
      end
      start = (cyc_no == restart_at) || (fin_start && cyc_no == exp_done);
      cyc();
      budget--;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    check("done_once", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("first_valid_cycle", 32'(first_valid), 32'd2);
    check("word_count", 32'(words), 32'(NUM_IN));
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("scan_sum", 32'(sum), 32'(exp_sum));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_mux_sel", 32'(bus.mux_sel), 32'd0);
  endtask

  initial begin
    int b;
    for (int k = 0; k < NUM_IN; k++) in_words[k] = DATA_W'(16'h1000 + k);
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    words = 0;
    done_cnt = 0;
    done_cyc = -1;
    first_valid = -1;

    // Reset values
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_mux_sel", 32'(bus.mux_sel), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    cyc();

    // Straight scan, consumer always ready
    run_scan(-1, 0, -1, 1'b0, 2 * NUM_IN + 1);
    check("scan_sum_const", 32'(sum), 32'h0A02D);

    // Backpressure on index 3 for five cycles
    run_scan(3, 5, -1, 1'b0, 2 * NUM_IN + 1 + 5);
    check("stall_sum_const", 32'(sum), 32'h0A02D);

    // Full-scale words plus ignored start pulses mid-scan and in FIN
    for (int k = 0; k < NUM_IN; k++) in_words[k] = 16'hFFFF;
    run_scan(-1, 0, 7, 1'b1, 2 * NUM_IN + 1);
    check("max_sum_const", 32'(sum), 32'h9FFF6);

    // Reset while index 5 is waiting in SEND
    for (int k = 0; k < NUM_IN; k++) in_words[k] = DATA_W'(16'h1000 + k);
    load_sb();
    words = 0;
    done_cnt = 0;
    first_valid = -1;
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cnt;
    cyc();
    start = 1'b0;
    b = 0;
    while (!(bus.out_valid === 1'b1 && bus.out_idx == SEL_W'(5)) && b < 50) begin
      cyc();
      b++;
    end
    check("reach_idx5", 32'(bus.out_idx), 32'd5);
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_mux_sel", 32'(bus.mux_sel), 32'd0);
    repeat (3) cyc();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_words", 32'(words), 32'd5);
    sb.delete();

    // Clean scan after the abort with fresh data
    for (int k = 0; k < NUM_IN; k++) in_words[k] = DATA_W'(16'h0100 * k + 16'h0033);
    run_scan(-1, 0, -1, 1'b0, 2 * NUM_IN + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
